axis_border_pad: RTL and testbench
==================================

// Module: axis_border_pad
// PURPOSE
//  Parametrised AXI4-Stream border padder; successor to the fixed zero-pad stage in front of the conv windows.
//  Adds runtime-configurable top/bottom/left/right borders to a multi-channel raster frame.
//  Supports three fill modes: zero, constant and horizontal edge-replicate.
//  Streams with one output register stage, no internal FIFO; sits between the frame source and the line-buffer/conv window.
// PARAMETERS
//  NUM_CH    3   channels per pixel, packed LSB-first in tdata
//  CH_W      8   bits per channel; TDATA_W = NUM_CH*CH_W
//  DIM_W     12  width of image-dimension config fields
//  PAD_W     4   width of each border-size config field (max pad 2^PAD_W-1)
// PORTS
//  clk           in   1            clock
//  resetn        in   1            synchronous active-low reset
//  cfg_width     in   DIM_W        input pixels per row (>=1)
//  cfg_height    in   DIM_W        input rows per frame (>=1)
//  cfg_pad_top   in   PAD_W        zero/const rows above image
//  cfg_pad_bot   in   PAD_W        rows below image
//  cfg_pad_left  in   PAD_W        pixels left of each image row
//  cfg_pad_right in   PAD_W        pixels right of each image row
//  cfg_mode      in   2            0=ZERO 1=CONST 2=REPLICATE 3=reserved(treated as ZERO)
//  cfg_const     in   TDATA_W      fill value for CONST mode (and for top/bottom in REPLICATE)
//  s_axis_tdata  in   TDATA_W      input pixel
//  s_axis_tvalid in   1            input valid
//  s_axis_tready out  1            input ready
//  s_axis_tlast  in   1            end of input row
//  s_axis_tuser  in   1            start of frame
//  m_axis_tdata  out  TDATA_W      output pixel
//  m_axis_tvalid out  1            output valid
//  m_axis_tready in   1            output ready
//  m_axis_tlast  out  1            end of output row
//  m_axis_tuser  out  1            first beat of output frame
//  busy          out  1            frame in progress (state != IDLE)
//  err_len       out  1            sticky row-length error, cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, s_axis_tready 0, state IDLE, counters 0, err_len 0.
//  cfg_* latched into shadow regs when a frame starts; changes mid-frame have no effect.
//  States: IDLE -> TOP -> (LEFT -> BODY -> RIGHT) x H -> BOT -> IDLE; zero-size sections skipped same cycle.
//  IDLE: s_axis_tready=1 for beats with tuser=0 (dropped, resync); beat with tvalid&tuser starts frame
//   without consuming it (tready=0 on that beat), latches cfg, goes to first non-empty section.
//  Output reg: load allowed when !m_axis_tvalid || m_axis_tready; tvalid held with stable data until taken.
//  Latency: input beat accepted at edge N appears on m_axis at edge N+1; full throughput 1 beat/clk.
//  BODY: s_axis_tready = load-allowed; all other states tready=0 (except IDLE rule).
//  Output frame: (W+L+R) x (H+T+B) beats; tuser=1 only on first beat; tlast on last beat of every row.
//  Fill value: ZERO->0; CONST->cfg_const; REPLICATE: left = current row's first input pixel (peeked from
//   s_axis_tdata while tvalid, LEFT waits for tvalid), right = last accepted pixel of row, top/bot = cfg_const.
//  Input tuser is ignored after frame start (consumed as data).
//  Early tlast (col < W-1): err_len=1; remaining body columns emitted as fill value without consuming input.
//  Missing tlast at col W-1: err_len=1; row ends on count regardless.
//  All pads 0: pure pass-through with 1-cycle latency, tlast/tuser regenerated from counters.
//  Column/row counters DIM_W+1 bits; compare against latched W+L+R-1 / H+T+B-1; no wrap inside a frame.
//  m_axis_tready low for any duration: no beat lost or duplicated, no input consumed.
//  Reset mid-frame: immediate return to IDLE, output valid dropped, partial frame discarded.
// STRUCTURE
//  Package pad_pkg: state localparams (IDLE,TOP,LEFT,BODY,RIGHT,BOT), mode constants MODE_ZERO/CONST/REPL.
//  One sub-module: axis_out_reg (valid/data/last/user holding register with load-allowed output).
//  Top: FSM + row/col counters + fill-value mux + replicate holding regs.
// TESTING
//  W=4,H=3,pads=1,ZERO, ready=1 -> 6x5 beats, border 0, tuser on beat 0, tlast every 6th beat.
//  Same, CONST=0x0A0B0C, T=2,B=0,L=0,R=3 -> 7x5 beats, border=0x0A0B0C, body pixels in order.
//  REPLICATE L=2,R=2, row [5,6,7,8] -> out row 5,5,5,6,7,8,8,8.
//  Random m_axis_tready (50%) and s_axis_tvalid gaps -> output identical to ready=1 reference model.
//  Row with tlast at col 1 (W=4) -> err_len=1, cols 2..3 filled, frame still 6x5 beats.
//  Beats without tuser in IDLE dropped; resetn pulse mid-body -> tvalid=0 next cycle, next frame correct.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared state encoding and fill-mode constants for the AXI4-Stream border padder.
package pad_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOP,
        ST_LEFT,
        ST_BODY,
        ST_RIGHT,
        ST_BOT
    } state_t;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_REPL  = 2'd2;
endpackage

// File: rtl/axis_border_pad_out_reg.sv
// Single-stage AXI4-Stream holding register; data stays stable while valid waits for ready.
module axis_out_reg #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              last,
    input  logic              user,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              load_ok
);
    assign load_ok = !m_tvalid || m_tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (load_ok) begin
            m_tvalid <= load;
            if (load) begin
                m_tdata <= data;
                m_tlast <= last;
                m_tuser <= user;
            end
        end
    end
endmodule

// File: rtl/axis_border_pad.sv
// Runtime-configurable border padder: walks the padded raster with row/col counters and
// pulls input pixels only while the walk is inside the image body.
module axis_border_pad
    import pad_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int DIM_W  = 12,
    parameter int PAD_W  = 4,
    localparam int TDATA_W = NUM_CH * CH_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [PAD_W-1:0]   cfg_pad_top,
    input  logic [PAD_W-1:0]   cfg_pad_bot,
    input  logic [PAD_W-1:0]   cfg_pad_left,
    input  logic [PAD_W-1:0]   cfg_pad_right,
    input  logic [1:0]         cfg_mode,
    input  logic [TDATA_W-1:0] cfg_const,
    input  logic [TDATA_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tuser,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               busy,
    output logic               err_len
);
    localparam int CNT_W = DIM_W + 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   col, row, col_nxt, row_nxt;
    // Section boundaries: top rows end, body rows end, left cols end, body cols end, last col/row.
    logic [CNT_W-1:0]   te, be, le, ce, lc, lr;
    logic [CNT_W-1:0]   c_te, c_be, c_le, c_ce, c_lc, c_lr;
    logic [1:0]         mode;
    logic [TDATA_W-1:0] cnst, last_pix, fill, out_data;
    logic               row_ended, fire, avail, s_ready, load_ok, start, take;

    assign c_te = CNT_W'(cfg_pad_top);
    assign c_be = CNT_W'(cfg_pad_top) + CNT_W'(cfg_height);
    assign c_le = CNT_W'(cfg_pad_left);
    assign c_ce = CNT_W'(cfg_pad_left) + CNT_W'(cfg_width);
    assign c_lc = c_ce + CNT_W'(cfg_pad_right) - ONE;
    assign c_lr = c_be + CNT_W'(cfg_pad_bot) - ONE;

    function automatic state_t section(input logic [CNT_W-1:0] r, c, t_end, b_end, l_end, c_end);
        if (r < t_end)       return ST_TOP;
        else if (r >= b_end) return ST_BOT;
        else if (c < l_end)  return ST_LEFT;
        else if (c < c_end)  return ST_BODY;
        else                 return ST_RIGHT;
    endfunction

    assign start = (state == ST_IDLE) && s_axis_tvalid && s_axis_tuser;
    assign take  = (state == ST_BODY) && s_ready && s_axis_tvalid;

    always_comb begin
        fill = '0;
        case (mode)
            MODE_CONST: fill = cnst;
            MODE_REPL: begin
                case (state)
                    ST_LEFT:           fill = s_axis_tdata;
                    ST_BODY, ST_RIGHT: fill = last_pix;
                    default:           fill = cnst;
                endcase
            end
            default: fill = '0;
        endcase
        out_data = (state == ST_BODY && !row_ended) ? s_axis_tdata : fill;
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        avail     = 1'b0;
        s_ready   = 1'b0;
        fire      = 1'b0;
        if (state == ST_IDLE) begin
            s_ready = !s_axis_tuser;
            if (start) begin
                col_nxt   = '0;
                row_nxt   = '0;
                state_nxt = section('0, '0, c_te, c_be, c_le, c_ce);
            end
        end else begin
            case (state)
                ST_LEFT: avail = (mode != MODE_REPL) || s_axis_tvalid;
                ST_BODY: begin
                    avail   = row_ended || s_axis_tvalid;
                    s_ready = load_ok && !row_ended;
                end
                default: avail = 1'b1;
            endcase
            fire = avail && load_ok;
            if (fire) begin
                if (col == lc) begin
                    col_nxt   = '0;
                    row_nxt   = row + ONE;
                    state_nxt = (row == lr) ? ST_IDLE : section(row + ONE, '0, te, be, le, ce);
                end else begin
                    col_nxt   = col + ONE;
                    state_nxt = section(row, col + ONE, te, be, le, ce);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            {te, be, le, ce, lc, lr} <= '0;
            mode      <= MODE_ZERO;
            cnst      <= '0;
            last_pix  <= '0;
            row_ended <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
            if (start) begin
                {te, be, le, ce, lc, lr} <= {c_te, c_be, c_le, c_ce, c_lc, c_lr};
                mode <= cfg_mode;
                cnst <= cfg_const;
            end
            if (fire && col == lc)
                row_ended <= 1'b0;
            // Short row: remaining body columns become fill; long row: cut on count.
            if (take) begin
                last_pix <= s_axis_tdata;
                if (s_axis_tlast && col != ce - ONE) begin
                    row_ended <= 1'b1;
                    err_len   <= 1'b1;
                end
                if (!s_axis_tlast && col == ce - ONE)
                    err_len <= 1'b1;
            end
        end
    end

    assign s_axis_tready = resetn && s_ready;
    assign busy          = (state != ST_IDLE);

    axis_out_reg #(.DATA_W(TDATA_W)) u_out (
        .clk     (clk),
        .resetn  (resetn),
        .load    (fire),
        .data    (out_data),
        .last    (col == lc),
        .user    (row == '0 && col == '0),
        .m_tready(m_axis_tready),
        .m_tdata (m_axis_tdata),
        .m_tvalid(m_axis_tvalid),
        .m_tlast (m_axis_tlast),
        .m_tuser (m_axis_tuser),
        .load_ok (load_ok)
    );
endmodule

// File: tb/tb_axis_border_pad.sv
// Self-checking bench: table of frame configurations checked against a raster-level model,
// plus hand sequences for reset, idle resync and mid-frame reset.
module tb_axis_border_pad;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] cfg_width = '0, cfg_height = '0;
    logic [3:0]  cfg_pad_top = '0, cfg_pad_bot = '0, cfg_pad_left = '0, cfg_pad_right = '0;
    logic [1:0]  cfg_mode = '0;
    logic [23:0] cfg_const = '0;
    logic [23:0] s_axis_tdata = '0, m_axis_tdata;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, m_axis_tuser;
    logic        busy, err_len;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_border_pad dut (
        .clk(clk), .resetn(resetn),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_pad_top(cfg_pad_top), .cfg_pad_bot(cfg_pad_bot),
        .cfg_pad_left(cfg_pad_left), .cfg_pad_right(cfg_pad_right),
        .cfg_mode(cfg_mode), .cfg_const(cfg_const),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .err_len(err_len)
    );

    typedef struct {
        int w, h, t, b, l, r;
        int mode;
        logic [23:0] cnst;
        int base;          // 0: random pixels, else base + running index
        int early_row;     // row with a short (early tlast) input, -1 for none
        int early_len;
        int gap;           // % of cycles with tvalid low
        int rdy;           // % of cycles with m_axis_tready high
        int exp_beats;
        bit exp_err;
    } tcase_t;

    tcase_t cases[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input tcase_t tc, input int idx, input bit do_reset);
        logic [23:0] pix[16][16];
        int          rlen[16];
        logic [23:0] bdata[$];
        bit          blast[$], buser[$];
        logic [25:0] exp_q[$], got[$];
        int          tw, th, k, ir;
        logic [23:0] v, fillv;
        bit          done;
        int          rep[8] = '{5, 5, 5, 6, 7, 8, 8, 8};

        for (int rr = 0; rr < tc.h; rr++) begin
            rlen[rr] = (rr == tc.early_row) ? tc.early_len : tc.w;
            for (int c = 0; c < tc.w; c++)
                pix[rr][c] = (tc.base != 0) ? 24'(tc.base + rr * tc.w + c) : 24'($urandom);
        end
        for (int rr = 0; rr < tc.h; rr++)
            for (int c = 0; c < rlen[rr]; c++) begin
                bdata.push_back(pix[rr][c]);
                blast.push_back(c == rlen[rr] - 1);
                buser.push_back(rr == 0 && c == 0);
            end

        // Reference raster: every output position computed directly from the fill rules.
        tw = tc.w + tc.l + tc.r;
        th = tc.h + tc.t + tc.b;
        fillv = (tc.mode == 1) ? tc.cnst : 24'h0;
        for (int rr = 0; rr < th; rr++)
            for (int c = 0; c < tw; c++) begin
                if (rr < tc.t || rr >= tc.t + tc.h) begin
                    v = (tc.mode == 1 || tc.mode == 2) ? tc.cnst : 24'h0;
                end else begin
                    ir = rr - tc.t;
                    k = c - tc.l;
                    if (c < tc.l)
                        v = (tc.mode == 2) ? pix[ir][0] : fillv;
                    else if (k < tc.w && k < rlen[ir])
                        v = pix[ir][k];
                    else
                        v = (tc.mode == 2) ? pix[ir][rlen[ir] - 1] : fillv;
                end
                exp_q.push_back({rr == 0 && c == 0, c == tw - 1, v});
            end

        cfg_width = 12'(tc.w);       cfg_height = 12'(tc.h);
        cfg_pad_top = 4'(tc.t);      cfg_pad_bot = 4'(tc.b);
        cfg_pad_left = 4'(tc.l);     cfg_pad_right = 4'(tc.r);
        cfg_mode = 2'(tc.mode);      cfg_const = tc.cnst;
        if (do_reset) begin
            resetn = 1'b0;
            tick();
            tick();
            resetn = 1'b1;
        end

        done = 1'b0;
        fork
            begin : driver
                int i = 0, cyc = 0;
                bit acc;
                while (i < bdata.size() && cyc < 3000) begin
                    if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 99) >= tc.gap);
                    s_axis_tdata = bdata[i];
                    s_axis_tlast = blast[i];
                    s_axis_tuser = buser[i];
                    @(negedge clk);
                    acc = s_axis_tvalid && s_axis_tready;
                    tick();
                    cyc++;
                    if (acc) begin
                        i++;
                        s_axis_tvalid = 1'b0;
                    end
                end
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 1'b0;
                chk($sformatf("case%0d input consumed", idx), 32'(i), 32'(bdata.size()));
            end
            begin : ready_gen
                while (!done) begin
                    m_axis_tready = ($urandom_range(0, 99) < tc.rdy);
                    tick();
                end
                m_axis_tready = 1'b1;
            end
            begin : monitor
                int cyc = 0;
                while (got.size() < exp_q.size() && cyc < 3000) begin
                    @(negedge clk);
                    if (m_axis_tvalid && m_axis_tready)
                        got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
                    cyc++;
                end
                done = 1'b1;
            end
        join

        repeat (3) tick();
        chk($sformatf("case%0d beat count", idx), 32'(got.size()), 32'(tc.exp_beats));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("case%0d beat%0d {user,last,data}", idx, i), 32'(got[i]), 32'(exp_q[i]));
        if (idx == 2)
            for (int i = 0; i < 8 && i < got.size(); i++)
                chk($sformatf("replicate row px%0d", i), 32'(got[i][23:0]), 32'(rep[i]));
        chk($sformatf("case%0d err_len", idx), 32'(err_len), 32'(tc.exp_err));
        chk($sformatf("case%0d busy after frame", idx), 32'(busy), 32'h0);
    endtask

    initial begin
        //          w  h  t  b  l  r  mode cnst       base early len gap rdy beats err
        cases[0] = '{4, 3, 1, 1, 1, 1, 0, 24'h0,     1,  -1, 0,  0, 100, 30, 0};
        cases[1] = '{4, 3, 2, 0, 0, 3, 1, 24'h0A0B0C, 16, -1, 0,  0, 100, 35, 0};
        cases[2] = '{4, 1, 0, 0, 2, 2, 2, 24'h123456, 5,  -1, 0,  0, 100, 8,  0};
        cases[3] = '{5, 4, 1, 2, 3, 1, 2, 24'hABCDEF, 0,  -1, 0, 30,  50, 63, 0};
        cases[4] = '{4, 3, 1, 1, 1, 1, 0, 24'h0,     1,   1, 2, 20,  50, 30, 1};
        cases[5] = '{5, 2, 0, 0, 0, 0, 3, 24'hFFFFFF, 0,  -1, 0, 20,  50, 10, 0};
        cases[6] = '{3, 2, 1, 1, 1, 2, 1, 24'h55AA55, 0,  -1, 0, 40,  50, 24, 0};

        // Reset state while resetn is held low.
        tick();
        @(negedge clk);
        chk("reset m_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("reset s_tready", 32'(s_axis_tready), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset err_len", 32'(err_len), 32'h0);
        chk("reset m_tdata", 32'(m_axis_tdata), 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // Idle beats without tuser are dropped and never start a frame.
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = 1'b0;
            s_axis_tdata  = 24'(i + 100);
            @(negedge clk);
            chk($sformatf("idle drop%0d tready", i), 32'(s_axis_tready), 32'h1);
            tick();
            chk($sformatf("idle drop%0d busy", i), 32'(busy), 32'h0);
            chk($sformatf("idle drop%0d m_tvalid", i), 32'(m_axis_tvalid), 32'h0);
        end
        s_axis_tvalid = 1'b0;

        for (int i = 0; i < 7; i++)
            run_case(cases[i], i, 1'b1);

        // Reset in the middle of the body, then a clean frame without any further reset.
        cfg_width = 12'd4;  cfg_height = 12'd3;
        cfg_pad_top = 4'd1; cfg_pad_bot = 4'd1; cfg_pad_left = 4'd1; cfg_pad_right = 4'd1;
        cfg_mode = 2'd0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b1;
        s_axis_tdata  = 24'h7;
        tick();
        s_axis_tuser = 1'b0;
        repeat (8) tick();
        chk("mid-frame busy", 32'(busy), 32'h1);
        resetn = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        chk("mid-frame reset m_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("mid-frame reset busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        tick();
        run_case(cases[0], 7, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
